// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending payment controller.
// Holds the state encoding, coin codes and the coin value lookup.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE,
        S_DONE
    } state_t;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        v = 4'd1;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_5:  v = 4'd5;
            COIN_10: v = 4'd10;
            default: v = 4'd1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy change picker: largest coin not exceeding the amount owed.
// Purely combinational; an owed value of zero maps to the 1-unit code.
module change_coin_select
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 9
) (
    input  logic [CREDIT_W-1:0] owed,
    output logic [1:0]          code
);

    // Pick the biggest denomination that still fits in owed
    always_comb begin
        code = COIN_1;
        if (owed >= CREDIT_W'(10))
            code = COIN_10;
        else if (owed >= CREDIT_W'(5))
            code = COIN_5;
        else if (owed >= CREDIT_W'(2))
            code = COIN_2;
        else
            code = COIN_1;
    end

endmodule

// File: rtl/vend_payment_ctrl.sv
// Payment controller: collects coins against a latched price, vends,
// then pays change one coin per handshake. Cancel/timeout refund all.
module vend_payment_ctrl
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CREDIT_W       = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          price,
    input  logic                start,
    input  logic                cancel,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                chg_valid,
    output logic [1:0]          chg_code,
    input  logic                chg_ready,
    output logic                done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [7:0]          price_q;
    logic [CREDIT_W-1:0] owed;
    logic [TW-1:0]       timer;

    logic [CREDIT_W-1:0] coin_amt;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] chg_amt;
    logic [CREDIT_W-1:0] price_ext;
    logic [1:0]          sel_code;
    logic                timed_out;
    logic                abort;
    logic                paid;
    logic                handshake;

    change_coin_select #(.CREDIT_W(CREDIT_W)) u_sel (
        .owed (owed),
        .code (sel_code)
    );

    assign coin_amt   = CREDIT_W'(coin_value(coin_code));
    assign credit_sum = coin_valid ? credit + coin_amt : credit;
    assign chg_amt    = CREDIT_W'(coin_value(sel_code));
    assign price_ext  = CREDIT_W'(price_q);
    assign timed_out  = !coin_valid && (timer == T_LAST);
    assign abort      = cancel || timed_out;
    assign paid       = credit >= price_ext;
    assign handshake  = chg_valid && chg_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        dispense   = (state == S_VEND);
        chg_valid  = (state == S_CHANGE) && (owed != '0);
        chg_code   = chg_valid ? sel_code : COIN_1;
        done       = (state == S_DONE);
        case (state)
            S_IDLE:
                if (start && price != '0)
                    state_next = S_COLLECT;
            S_COLLECT:
                if (abort)
                    state_next = S_CHANGE;
                else if (paid)
                    state_next = S_VEND;
            S_VEND:
                state_next = S_CHANGE;
            S_CHANGE:
                if (owed == '0)
                    state_next = S_DONE;
            S_DONE:
                state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    // Price latch, credit accumulator, change counter and idle timer
    always_ff @(posedge clk) begin
        if (rst) begin
            price_q <= '0;
            credit  <= '0;
            owed    <= '0;
            timer   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && price != '0) begin
                        price_q <= price;
                        credit  <= '0;
                        owed    <= '0;
                        timer   <= '0;
                    end
                end
                S_COLLECT: begin
                    credit <= credit_sum;
                    timer  <= coin_valid ? '0 : timer + TW'(1);
                    if (abort)
                        owed <= credit_sum;
                end
                S_VEND: begin
                    owed <= credit - price_ext;
                end
                S_CHANGE: begin
                    if (handshake)
                        owed <= owed - chg_amt;
                end
                S_DONE: begin
                    credit <= '0;
                    owed   <= '0;
                end
                default: begin
                    owed <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Directed bench for vend_payment_ctrl with a short timeout.
// Each step advances one clock and checks outputs 1 ns after the edge.
module tb_vend_payment_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] price;
    logic       start;
    logic       cancel;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       busy;
    logic [8:0] credit;
    logic       dispense;
    logic       chg_valid;
    logic [1:0] chg_code;
    logic       chg_ready;
    logic       done;

    int checks = 0;
    int errors = 0;

    vend_payment_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CREDIT_W       (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .price      (price),
        .start      (start),
        .cancel     (cancel),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .busy       (busy),
        .credit     (credit),
        .dispense   (dispense),
        .chg_valid  (chg_valid),
        .chg_code   (chg_code),
        .chg_ready  (chg_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; price = 8'd0; start = 1'b0; cancel = 1'b0;
        coin_valid = 1'b0; coin_code = 2'b00; chg_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_credit", 16'(credit), 16'd0);
        chk("rst_disp", 16'(dispense), 16'd0);
        chk("rst_cv", 16'(chg_valid), 16'd0);
        chk("rst_cc", 16'(chg_code), 16'd0);
        chk("rst_done", 16'(done), 16'd0);

        // 1: exact payment, price 15 with 10 then 5
        price = 8'd15; start = 1'b1; cyc(); start = 1'b0;
        chk("t1_busy", 16'(busy), 16'd1);
        chk("t1_credit0", 16'(credit), 16'd0);
        coin_valid = 1'b1; coin_code = 2'b11; cyc();
        coin_code = 2'b10; cyc(); coin_valid = 1'b0;
        chk("t1_credit", 16'(credit), 16'd15);
        chk("t1_nodisp", 16'(dispense), 16'd0);
        cyc();
        chk("t1_disp", 16'(dispense), 16'd1);
        cyc();
        chk("t1_disp_end", 16'(dispense), 16'd0);
        chk("t1_nochg", 16'(chg_valid), 16'd0);
        cyc();
        chk("t1_done", 16'(done), 16'd1);
        chk("t1_nochg2", 16'(chg_valid), 16'd0);
        cyc();
        chk("t1_done_end", 16'(done), 16'd0);
        chk("t1_idle", 16'(busy), 16'd0);
        chk("t1_clr", 16'(credit), 16'd0);

        // 2: overpay, price 9 with a 10 -> one 1-unit coin back
        price = 8'd9; start = 1'b1; cyc(); start = 1'b0;
        coin_valid = 1'b1; coin_code = 2'b11; cyc(); coin_valid = 1'b0;
        cyc();
        chk("t2_disp", 16'(dispense), 16'd1);
        cyc();
        chk("t2_cv", 16'(chg_valid), 16'd1);
        chk("t2_cc", 16'(chg_code), 16'd0);
        chg_ready = 1'b1; cyc();
        chk("t2_cv_end", 16'(chg_valid), 16'd0);
        chg_ready = 1'b0; cyc();
        chk("t2_done", 16'(done), 16'd1);
        cyc();
        chk("t2_idle", 16'(busy), 16'd0);

        // 3: cancel after a 5 -> 5 refunded, no vend
        price = 8'd9; start = 1'b1; cyc(); start = 1'b0;
        coin_valid = 1'b1; coin_code = 2'b10; cyc(); coin_valid = 1'b0;
        cancel = 1'b1; cyc(); cancel = 1'b0;
        chk("t3_nodisp", 16'(dispense), 16'd0);
        chk("t3_cv", 16'(chg_valid), 16'd1);
        chk("t3_cc", 16'(chg_code), 16'd2);
        chg_ready = 1'b1; cyc();
        chk("t3_cv_end", 16'(chg_valid), 16'd0);
        chk("t3_nodisp2", 16'(dispense), 16'd0);
        chg_ready = 1'b0; cyc();
        chk("t3_done", 16'(done), 16'd1);
        cyc();
        chk("t3_clr", 16'(credit), 16'd0);

        // 4: price 2 paid with 10, hopper stalls, then 5,2,1
        price = 8'd2; start = 1'b1; cyc(); start = 1'b0;
        coin_valid = 1'b1; coin_code = 2'b11; cyc(); coin_valid = 1'b0;
        cyc();
        chk("t4_disp", 16'(dispense), 16'd1);
        cyc();
        chk("t4_stall0_v", 16'(chg_valid), 16'd1);
        chk("t4_stall0_c", 16'(chg_code), 16'd2);
        cyc();
        chk("t4_stall1_v", 16'(chg_valid), 16'd1);
        chk("t4_stall1_c", 16'(chg_code), 16'd2);
        cyc();
        chk("t4_stall2_c", 16'(chg_code), 16'd2);
        chg_ready = 1'b1; cyc();
        chk("t4_c2_v", 16'(chg_valid), 16'd1);
        chk("t4_c2", 16'(chg_code), 16'd1);
        cyc();
        chk("t4_c1", 16'(chg_code), 16'd0);
        chk("t4_c1_v", 16'(chg_valid), 16'd1);
        cyc();
        chk("t4_owed0", 16'(chg_valid), 16'd0);
        chg_ready = 1'b0; cyc();
        chk("t4_done", 16'(done), 16'd1);
        cyc();
        chk("t4_idle", 16'(busy), 16'd0);

        // 5a: timeout, price 15, one 2 then nothing
        price = 8'd15; start = 1'b1; cyc(); start = 1'b0;
        coin_valid = 1'b1; coin_code = 2'b01; cyc(); coin_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("t5_wait_v", 16'(chg_valid), 16'd0);
        chk("t5_wait_b", 16'(busy), 16'd1);
        cyc();
        chk("t5_to_v", 16'(chg_valid), 16'd1);
        chk("t5_to_c", 16'(chg_code), 16'd1);
        chk("t5_nodisp", 16'(dispense), 16'd0);
        chg_ready = 1'b1; cyc();
        chk("t5_to_end", 16'(chg_valid), 16'd0);
        chg_ready = 1'b0; cyc();
        chk("t5_done", 16'(done), 16'd1);
        cyc();

        // 5b: coin and cancel together -> refund 10 + 1
        price = 8'd15; start = 1'b1; cyc(); start = 1'b0;
        coin_valid = 1'b1; coin_code = 2'b11; cyc();
        coin_code = 2'b00; cancel = 1'b1; cyc();
        coin_valid = 1'b0; cancel = 1'b0;
        chk("t5b_credit", 16'(credit), 16'd11);
        chk("t5b_nodisp", 16'(dispense), 16'd0);
        chk("t5b_c10", 16'(chg_code), 16'd3);
        chg_ready = 1'b1; cyc();
        chk("t5b_c1", 16'(chg_code), 16'd0);
        chk("t5b_c1_v", 16'(chg_valid), 16'd1);
        cyc();
        chk("t5b_end", 16'(chg_valid), 16'd0);
        chg_ready = 1'b0; cyc();
        chk("t5b_done", 16'(done), 16'd1);
        cyc();

        // 6: reset mid-change, then start with price 0
        price = 8'd9; start = 1'b1; cyc(); start = 1'b0;
        coin_valid = 1'b1; coin_code = 2'b11; cyc(); coin_valid = 1'b0;
        cyc(); cyc();
        chk("t6_pre_cv", 16'(chg_valid), 16'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t6_busy", 16'(busy), 16'd0);
        chk("t6_credit", 16'(credit), 16'd0);
        chk("t6_cv", 16'(chg_valid), 16'd0);
        chk("t6_cc", 16'(chg_code), 16'd0);
        chk("t6_disp", 16'(dispense), 16'd0);
        chk("t6_done", 16'(done), 16'd0);
        price = 8'd0; start = 1'b1; cyc(); start = 1'b0;
        chk("t6_zero_busy", 16'(busy), 16'd0);
        cyc();
        chk("t6_zero_busy2", 16'(busy), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
